// File: rtl/mem_wb_if.sv
// MEM->WB stage channel: valid/ready handshake plus writeback payload.
// master drives valid and payload, slave drives ready.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] regaddr;

  modport master (output valid, ctrl, aluout, rdata, regaddr, input ready);
  modport slave  (input valid, ctrl, aluout, rdata, regaddr, output ready);
endinterface

// File: rtl/mem_wb_stage_reg.sv
// MEM->WB pipeline register with a 2-entry skid buffer, flush and masked bubbles.
// Optional MEM_WB_BUBBLE_CNT_EN adds a saturating count of idle output cycles.
module mem_wb_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 2,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  mem_wb_if.slave          mem,
  mem_wb_if.master         wb,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] regaddr;
  } entry_t;

  logic [1:0] state, state_nxt;
  entry_t     main_q, skid_q, in_entry;
  logic       main_valid, skid_valid;
  logic       accept, pop;
  logic       load_main_in, load_main_skid, load_skid;

  assign in_entry   = '{ctrl: mem.ctrl, aluout: mem.aluout, rdata: mem.rdata, regaddr: mem.regaddr};
  assign main_valid = (state == ONE) || (state == FULL);
  assign skid_valid = (state == FULL);

  // Ready comes from registered state only, so out_ready never reaches in_ready.
  assign mem.ready = !skid_valid && !rst;
  assign accept    = mem.valid && mem.ready;
  assign pop       = main_valid && wb.ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_nxt = FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush discards held entries and anything accepted this cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in)
        main_q <= in_entry;
      else if (load_main_skid)
        main_q <= skid_q;
      if (load_skid)
        skid_q <= in_entry;
    end
  end

  // Bubbles carry stale payload; masking ctrl keeps regwrite low.
  assign wb.valid   = main_valid;
  assign wb.ctrl    = main_valid ? main_q.ctrl : '0;
  assign wb.aluout  = main_q.aluout;
  assign wb.rdata   = main_q.rdata;
  assign wb.regaddr = main_q.regaddr;

`ifdef MEM_WB_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_q;

  always_ff @(posedge clk) begin
    if (rst)
      bubble_q <= '0;
    else if (!main_valid && (bubble_q != {CNT_W{1'b1}}))
      bubble_q <= bubble_q + 1'b1;
  end

  assign bubble_cnt = bubble_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Scoreboard bench for mem_wb_stage_reg: accepted entries are queued at the
// handshake and checked in order when WB consumes them.
module tb_mem_wb_stage_reg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 2;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] regaddr;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] bubble_cnt;
  int               n_cmp;
  int               n_bad;
  entry_t           sb[$];

  mem_wb_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) mem_bus ();
  mem_wb_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) wb_bus ();

  mem_wb_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .mem(mem_bus), .wb(wb_bus), .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor samples mid-cycle, when all inputs and outputs are settled.
  always @(negedge clk) begin
    entry_t exp_e, act_e;
    if (rst === 1'b1 || flush === 1'b1) begin
      sb.delete();
    end else begin
      if (wb_bus.valid === 1'b1 && wb_bus.ready === 1'b1) begin
        act_e = '{ctrl: wb_bus.ctrl, aluout: wb_bus.aluout, rdata: wb_bus.rdata, regaddr: wb_bus.regaddr};
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_pop_empty: got entry %h, required no output", act_e);
        end else begin
          exp_e = sb.pop_front();
          if (act_e !== exp_e) begin
            n_bad++;
            $display("FAIL sb_entry: got %h, required %h", act_e, exp_e);
          end
        end
      end
      if (mem_bus.valid === 1'b1 && mem_bus.ready === 1'b1)
        sb.push_back('{ctrl: mem_bus.ctrl, aluout: mem_bus.aluout, rdata: mem_bus.rdata, regaddr: mem_bus.regaddr});
    end
  end

  task automatic drive_in(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] a);
    mem_bus.valid   = v;
    mem_bus.ctrl    = c;
    mem_bus.aluout  = a;
    mem_bus.rdata   = ~a;
    mem_bus.regaddr = a[ADDR_W-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if (wb_bus.valid !== 1'b0 || wb_bus.ctrl !== '0) begin
      n_bad++;
      $display("FAIL reset_valid_ctrl: got valid=%b ctrl=%b, required 0/0", wb_bus.valid, wb_bus.ctrl);
    end
    n_cmp++;
    if (wb_bus.aluout !== '0 || wb_bus.rdata !== '0 || wb_bus.regaddr !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h %h %h, required zeros", wb_bus.aluout, wb_bus.rdata, wb_bus.regaddr);
    end
    n_cmp++;
    if (mem_bus.ready !== 1'b0 || bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_ready_cnt: got ready=%b cnt=%0d, required 0/0", mem_bus.ready, bubble_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: got %b, required 1", mem_bus.ready);
    end
  endtask

  task automatic test_stream();
    wb_bus.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_in(1'b1, 2'b11, DATA_W'(i));
      step();
      n_cmp++;
      if (wb_bus.valid !== 1'b1 || wb_bus.aluout !== DATA_W'(i)) begin
        n_bad++;
        $display("FAIL stream_%0d: got valid=%b aluout=%0d, required 1/%0d", i, wb_bus.valid, wb_bus.aluout, i);
      end
    end
    drive_in(1'b0, 2'b00, '0);
    step();
  endtask

  task automatic test_backpressure();
    wb_bus.ready = 1'b0;
    drive_in(1'b1, 2'b01, 32'hA);
    step();
    drive_in(1'b1, 2'b10, 32'hB);
    step();
    n_cmp++;
    if (mem_bus.ready !== 1'b0 || wb_bus.aluout !== 32'hA) begin
      n_bad++;
      $display("FAIL bp_full: got ready=%b aluout=%h, required 0/a", mem_bus.ready, wb_bus.aluout);
    end
    drive_in(1'b1, 2'b11, 32'hC);
    step();
    n_cmp++;
    if (mem_bus.ready !== 1'b0 || wb_bus.aluout !== 32'hA || wb_bus.ctrl !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_hold: got ready=%b aluout=%h ctrl=%b, required 0/a/01", mem_bus.ready, wb_bus.aluout, wb_bus.ctrl);
    end
    wb_bus.ready = 1'b1;
    step();
    step();
    drive_in(1'b0, 2'b00, '0);
    step();
    step();
    step();
    n_cmp++;
    if (sb.size() != 0 || wb_bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drain: got %0d pending valid=%b, required 0/0", sb.size(), wb_bus.valid);
    end
  endtask

  task automatic test_flush();
    wb_bus.ready = 1'b0;
    drive_in(1'b1, 2'b11, 32'hD);
    step();
    drive_in(1'b1, 2'b11, 32'hE);
    step();
    drive_in(1'b1, 2'b01, 32'hF);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, 2'b00, '0);
    n_cmp++;
    if (wb_bus.valid !== 1'b0 || wb_bus.ctrl !== '0 || mem_bus.ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_full: got valid=%b ctrl=%b ready=%b, required 0/00/1", wb_bus.valid, wb_bus.ctrl, mem_bus.ready);
    end
    step();
    n_cmp++;
    if (wb_bus.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_full_nowrite: got valid=%b, required 0", wb_bus.valid);
    end
    drive_in(1'b1, 2'b11, 32'h10);
    step();
    drive_in(1'b1, 2'b01, 32'h11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive_in(1'b0, 2'b00, '0);
    step();
    n_cmp++;
    if (wb_bus.valid !== 1'b0 || wb_bus.ctrl !== '0) begin
      n_bad++;
      $display("FAIL flush_one_discard: got valid=%b ctrl=%b, required 0/00", wb_bus.valid, wb_bus.ctrl);
    end
  endtask

  task automatic test_bubble();
    wb_bus.ready = 1'b1;
    drive_in(1'b0, 2'b01, 32'h55);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (wb_bus.valid !== 1'b0 || wb_bus.ctrl !== '0) begin
        n_bad++;
        $display("FAIL bubble_%0d: got valid=%b ctrl=%b, required 0/00", i, wb_bus.valid, wb_bus.ctrl);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic hold;
    logic acc;
    hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!hold)
        drive_in(1'($urandom_range(0, 1)), CTRL_W'($urandom), DATA_W'($urandom));
      wb_bus.ready = ($urandom_range(0, 3) != 0);
      acc  = mem_bus.valid && mem_bus.ready;
      hold = mem_bus.valid && !acc;
      step();
    end
    drive_in(1'b0, 2'b00, '0);
    wb_bus.ready = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: got %0d pending entries, required 0", sb.size());
    end
  endtask

  task automatic test_reset_full_and_count();
    logic [CNT_W-1:0] exp_cnt;
    wb_bus.ready = 1'b0;
    drive_in(1'b1, 2'b11, 32'h20);
    step();
    drive_in(1'b1, 2'b11, 32'h21);
    step();
    drive_in(1'b0, 2'b00, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (wb_bus.valid !== 1'b0 || wb_bus.aluout !== '0 || bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_full: got valid=%b aluout=%h cnt=%0d, required 0/0/0", wb_bus.valid, wb_bus.aluout, bubble_cnt);
    end
    repeat (20) step();
`ifdef MEM_WB_BUBBLE_CNT_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd0;
`endif
    n_cmp++;
    if (bubble_cnt !== exp_cnt) begin
      n_bad++;
      $display("FAIL bubble_cnt_sat: got %0d, required %0d", bubble_cnt, exp_cnt);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL bubble_cnt_rst: got %0d, required 0", bubble_cnt);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    flush = 1'b0;
    wb_bus.ready = 1'b0;
    drive_in(1'b0, 2'b00, '0);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_bubble();
    test_back_to_back();
    test_reset_full_and_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
